// File: rtl/uart_cmd_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_router_pkg
//  Description : Shared types and constants for the SPI-to-UART command
//                router: status codes, FSM state encoding, channel count.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_router_pkg;

    // Number of UART-attached modules on the board; default channel count.
    localparam int NUM_OF_MODULES = 9;

    // Id value that addresses every channel at once.
    localparam logic [7:0] c_BCAST_ID = 8'hFF;

    // Status byte returned in rsp_data[15:8].
    localparam logic [7:0] c_STATUS_OK        = 8'h00;
    localparam logic [7:0] c_STATUS_TIMEOUT   = 8'h01;
    localparam logic [7:0] c_STATUS_PARITY    = 8'h02;
    localparam logic [7:0] c_STATUS_BAD_ID    = 8'h03;
    localparam logic [7:0] c_STATUS_BCAST_ACK = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT_TX = 3'd2,
        S_WAIT_RX = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    // Counter width able to hold cycles-1; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_router_if
//  Description : Command/response and per-channel UART bundle of the router.
//                slave = router view, master = SPI core / UART bank view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_router_if
    import uart_cmd_router_pkg::*;
#(
    parameter int NUM_CH = NUM_OF_MODULES
);
    logic                  cmd_valid;
    logic [15:0]           cmd_data;
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic [15:0]           rsp_data;
    logic [NUM_CH-1:0]     start_tx;
    logic [8*NUM_CH-1:0]   data_to_tx;
    logic [NUM_CH-1:0]     tx_busy;
    logic [NUM_CH-1:0]     rx_done;
    logic [8*NUM_CH-1:0]   data_received;
    logic [NUM_CH-1:0]     parity_error;
    logic [7:0]            drop_count;
    logic                  router_busy;

    modport slave (
        input  cmd_valid, cmd_data, tx_busy, rx_done, data_received, parity_error,
        output cmd_ready, rsp_valid, rsp_data, start_tx, data_to_tx, drop_count,
               router_busy
    );

    modport master (
        output cmd_valid, cmd_data, tx_busy, rx_done, data_received, parity_error,
        input  cmd_ready, rsp_valid, rsp_data, start_tx, data_to_tx, drop_count,
               router_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_router_reply_timer.sv
`default_nettype none
// ============================================================================
//  Module      : reply_timer
//  Description : Loadable down-counter; o_tc is high while the count is zero.
//                Counting stops at zero until the next load.
//  Revision    : 1.0 - initial release
// ============================================================================
module reply_timer #(
    parameter int WIDTH = 16
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_value,
    input  wire              i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down while enabled and not expired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_router.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_router
//  Description : Routes {id, code} command words to per-module UART links,
//                collects the unicast reply with timeout, returns a status
//                word. Supports broadcast, id validation and drop counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_router
    import uart_cmd_router_pkg::*;
#(
    parameter int         NUM_CH         = NUM_OF_MODULES,
    parameter int         TIMEOUT_CYCLES = 48000,
    parameter logic [7:0] BCAST_ID       = c_BCAST_ID
) (
    input wire               clk,
    input wire               reset,
    uart_cmd_router_if.slave bus
);

    localparam int              c_TW         = timer_width(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TIMER_LOAD = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      c_NUM_CH     = 8'(NUM_CH);

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_id;
    logic [7:0]          r_code;
    logic                r_bcast;
    logic                r_blank;
    logic [7:0]          r_status;
    logic [7:0]          r_reply;

    logic                r_cmd_ready;
    logic                r_router_busy;
    logic [NUM_CH-1:0]   r_start_tx;
    logic [8*NUM_CH-1:0] r_data_to_tx;
    logic                r_rsp_valid;
    logic [15:0]         r_rsp_data;
    logic [7:0]          r_drop_count;

    logic [NUM_CH-1:0]   w_target;
    logic [7:0]          w_rx_byte;
    logic                w_targets_idle;
    logic                w_rx_hit;
    logic                w_rx_parity;
    logic                w_bad_id;
    logic                w_launch;
    logic                w_timer_load;
    logic                w_timer_tc;
    logic                w_set_rsp;
    logic [7:0]          w_rsp_status;
    logic [7:0]          w_rsp_reply;

    // Target mask and reply byte of the latched id; broadcast selects all.
    always_comb begin
        w_target  = '0;
        w_rx_byte = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_target[i] = r_bcast || (r_id == 8'(i));
            if (r_id == 8'(i)) begin
                w_rx_byte = bus.data_received[8*i +: 8];
            end
        end
    end

    assign w_targets_idle = ((bus.tx_busy & w_target) == '0);
    assign w_rx_hit       = |(bus.rx_done & w_target);
    assign w_rx_parity    = |(bus.rx_done & bus.parity_error & w_target);
    assign w_bad_id       = (bus.cmd_data[15:8] >= c_NUM_CH) &&
                            (bus.cmd_data[15:8] != BCAST_ID);

    reply_timer #(
        .WIDTH        (c_TW)
    ) u_reply_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (c_TIMER_LOAD),
        .i_en         (r_state == S_WAIT_RX),
        .o_tc         (w_timer_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the launch / timer-load / response-capture strobes.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_timer_load = 1'b0;
        w_set_rsp    = 1'b0;
        w_rsp_status = c_STATUS_OK;
        w_rsp_reply  = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_bad_id) begin
                        w_state_next = S_RESPOND;
                        w_set_rsp    = 1'b1;
                        w_rsp_status = c_STATUS_BAD_ID;
                    end else begin
                        w_state_next = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (w_targets_idle) begin
                    w_launch     = 1'b1;
                    w_state_next = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // The first cycle is skipped: tx_busy has not yet reacted to start_tx.
                if (!r_blank && w_targets_idle) begin
                    if (r_bcast) begin
                        w_state_next = S_RESPOND;
                        w_set_rsp    = 1'b1;
                        w_rsp_status = c_STATUS_BCAST_ACK;
                    end else begin
                        w_state_next = S_WAIT_RX;
                        w_timer_load = 1'b1;
                    end
                end
            end
            S_WAIT_RX: begin
                // A reply arriving on the terminal cycle still wins over the timeout.
                if (w_rx_hit) begin
                    w_state_next = S_RESPOND;
                    w_set_rsp    = 1'b1;
                    if (w_rx_parity) begin
                        w_rsp_status = c_STATUS_PARITY;
                    end else begin
                        w_rsp_reply  = w_rx_byte;
                    end
                end else if (w_timer_tc) begin
                    w_state_next = S_RESPOND;
                    w_set_rsp    = 1'b1;
                    w_rsp_status = c_STATUS_TIMEOUT;
                end
            end
            S_RESPOND: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, response capture and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id          <= '0;
            r_code        <= '0;
            r_bcast       <= 1'b0;
            r_blank       <= 1'b0;
            r_status      <= '0;
            r_reply       <= '0;
            r_cmd_ready   <= 1'b1;
            r_router_busy <= 1'b0;
            r_start_tx    <= '0;
            r_data_to_tx  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_drop_count  <= '0;
        end else begin
            r_cmd_ready   <= (w_state_next == S_IDLE);
            r_router_busy <= (w_state_next != S_IDLE);
            r_start_tx    <= w_launch ? w_target : '0;
            r_blank       <= w_launch;
            r_rsp_valid   <= (r_state == S_RESPOND);

            if ((r_state == S_IDLE) && bus.cmd_valid) begin
                r_id    <= bus.cmd_data[15:8];
                r_code  <= bus.cmd_data[7:0];
                r_bcast <= (bus.cmd_data[15:8] == BCAST_ID);
            end

            // Untargeted channels keep the byte they were last launched with.
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_launch && w_target[i]) begin
                    r_data_to_tx[8*i +: 8] <= r_code;
                end
            end

            if (w_set_rsp) begin
                r_status <= w_rsp_status;
                r_reply  <= w_rsp_reply;
            end

            if (r_state == S_RESPOND) begin
                r_rsp_data <= {r_status, r_reply};
            end

            if (bus.cmd_valid && !r_cmd_ready && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.router_busy = r_router_busy;
    assign bus.start_tx    = r_start_tx;
    assign bus.data_to_tx  = r_data_to_tx;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_router
//  Description : Self-checking bench for uart_cmd_router with a simple UART
//                busy model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_router;

    localparam int NUM_CH = 9;
    localparam int T_CYC  = 400;
    localparam int TX_LEN = 4;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    int                  cyc = 0;
    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  rsp_count = 0;
    exp_t                sb_q[$];

    logic                start_seen;
    int                  start_cyc;
    logic [NUM_CH-1:0]   start_mask;
    logic [8*NUM_CH-1:0] start_data;
    logic [NUM_CH-1:0]   seen_start = '0;
    logic [NUM_CH-1:0]   force_busy;
    logic [NUM_CH-1:0]   model_busy;
    int                  tx_cnt[NUM_CH];

    uart_cmd_router_if #(.NUM_CH(NUM_CH)) bus ();

    uart_cmd_router #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (T_CYC),
        .BCAST_ID       (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises on the edge after start_tx is seen, lasts TX_LEN cycles.
    initial for (int i = 0; i < NUM_CH; i++) tx_cnt[i] = 0;
    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (seen_start[i]) tx_cnt[i] <= TX_LEN;
            else if (tx_cnt[i] > 0) tx_cnt[i] <= tx_cnt[i] - 1;
        end
    end
    always_comb begin
        model_busy = '0;
        for (int i = 0; i < NUM_CH; i++) model_busy[i] = (tx_cnt[i] != 0);
    end
    assign bus.tx_busy = model_busy | force_busy;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Start-pulse capture and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        seen_start <= bus.start_tx;
        if (|bus.start_tx) begin
            start_seen = 1'b1;
            start_cyc  = cyc;
            start_mask = bus.start_tx;
            start_data = bus.data_to_tx;
        end
        if (bus.rsp_valid === 1'b1) begin
            exp_t e;
            rsp_count++;
            if (sb_q.size() == 0) begin
                check_value("rsp_unexpected", bus.rsp_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check_value("rsp_data", bus.rsp_data, e.data);
                if (e.cyc >= 0) check_value("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] d);
        start_seen    = 1'b0;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start_seen && n < 100) begin tick(); n++; end
        check_value(tag, start_seen, 1'b1);
    endtask

    task automatic wait_tx_idle(input int ch);
        int n = 0;
        while (bus.tx_busy[ch] && n < 100) begin tick(); n++; end
        tick();
        tick();
    endtask

    task automatic drive_rx(input int ch, input logic [7:0] d, input logic par, input logic [15:0] exp_rsp, input logic expect_rsp);
        bus.data_received[8*ch +: 8] = d;
        bus.rx_done[ch]      = 1'b1;
        bus.parity_error[ch] = par;
        if (expect_rsp) push_exp(exp_rsp, cyc + 2);
        tick();
        bus.rx_done      = '0;
        bus.parity_error = '0;
    endtask

    task automatic wait_sb_empty(input string tag, input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin tick(); n++; end
        check_value(tag, sb_q.size(), 0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cmd_ready"},   bus.cmd_ready,   1'b1);
        check_value({tag, "_router_busy"}, bus.router_busy, 1'b0);
        check_value({tag, "_start_tx"},    bus.start_tx,    '0);
        check_value({tag, "_data_to_tx"},  bus.data_to_tx,  '0);
        check_value({tag, "_rsp_valid"},   bus.rsp_valid,   1'b0);
        check_value({tag, "_rsp_data"},    bus.rsp_data,    16'h0000);
        check_value({tag, "_drop_count"},  bus.drop_count,  8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce;
        int rel;
        int rsp_before;
        reset             = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_data      = '0;
        bus.rx_done       = '0;
        bus.parity_error  = '0;
        bus.data_received = '0;
        force_busy        = '0;
        start_seen        = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Unicast OK on channel 3.
        send_cmd(16'h0342);
        check_value("uni_busy", bus.router_busy, 1'b1);
        wait_start("uni_start");
        check_value("uni_start_mask", start_mask, 9'b000001000);
        check_value("uni_data_tx3", start_data[8*3 +: 8], 8'h42);
        wait_tx_idle(3);
        drive_rx(3, 8'h5A, 1'b0, 16'h005A, 1'b1);
        wait_sb_empty("uni_drain", 50);
        check_value("uni_ready_after", bus.cmd_ready, 1'b1);

        // Timeout on channel 1.
        send_cmd(16'h0110);
        wait_start("to_start");
        ce = start_cyc;
        push_exp(16'h0100, ce + TX_LEN + T_CYC + 3);
        wait_sb_empty("to_drain", T_CYC + 50);

        // Reply on the terminal cycle beats the timeout.
        send_cmd(16'h0110);
        wait_start("term_start");
        ce = start_cyc;
        while (cyc < ce + TX_LEN + T_CYC + 1) tick();
        drive_rx(1, 8'hC3, 1'b0, 16'h00C3, 1'b1);
        wait_sb_empty("term_drain", 50);

        // Broadcast held off by a busy channel 5.
        force_busy[5] = 1'b1;
        push_exp(16'h0400, -1);
        send_cmd(16'hFF07);
        repeat (20) tick();
        check_value("bcast_held", start_seen, 1'b0);
        force_busy[5] = 1'b0;
        rel = cyc;
        wait_start("bcast_start");
        check_value("bcast_mask", start_mask, 9'h1FF);
        check_value("bcast_after_release", start_cyc > rel, 1'b1);
        check_value("bcast_data", start_data, {NUM_CH{8'h07}});
        wait_sb_empty("bcast_drain", 50);

        // Bad id: immediate BAD_ID, nothing launched, TX bytes held.
        push_exp(16'h0300, cyc + 2);
        send_cmd(16'h0A00);
        wait_sb_empty("badid_drain", 20);
        check_value("badid_no_start", start_seen, 1'b0);
        check_value("badid_data_hold", bus.data_to_tx, {NUM_CH{8'h07}});

        // Parity error on channel 2; traffic on channel 4 ignored.
        send_cmd(16'h0255);
        wait_start("par_start");
        wait_tx_idle(2);
        drive_rx(4, 8'h11, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        drive_rx(2, 8'h77, 1'b1, 16'h0200, 1'b1);
        wait_sb_empty("par_drain", 50);

        // Drops during WAIT_RX saturate at 255; transaction unaffected.
        send_cmd(16'h0611);
        wait_start("drop_start");
        wait_tx_idle(6);
        bus.cmd_data = 16'h0000;
        for (int i = 0; i < 100; i++) begin bus.cmd_valid = 1'b1; tick(); end
        bus.cmd_valid = 1'b0;
        check_value("drop_100", bus.drop_count, 8'd100);
        for (int i = 0; i < 200; i++) begin bus.cmd_valid = 1'b1; tick(); end
        bus.cmd_valid = 1'b0;
        check_value("drop_sat", bus.drop_count, 8'd255);
        check_value("drop_still_busy", bus.router_busy, 1'b1);
        drive_rx(6, 8'h3C, 1'b0, 16'h003C, 1'b1);
        wait_sb_empty("drop_drain", 50);

        // Reset during WAIT_RX aborts without a response.
        send_cmd(16'h0733);
        wait_start("rst_start");
        wait_tx_idle(7);
        rsp_before = rsp_count;
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (T_CYC + 20) tick();
        check_value("rst_no_rsp", rsp_count, rsp_before);

        // Normal operation after reset.
        send_cmd(16'h0842);
        wait_start("post_start");
        check_value("post_mask", start_mask, 9'b100000000);
        check_value("post_data_tx8", start_data[8*8 +: 8], 8'h42);
        wait_tx_idle(8);
        drive_rx(8, 8'h99, 1'b0, 16'h0099, 1'b1);
        wait_sb_empty("post_drain", 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
